// File: rtl/conv_pkg.sv
// Shared sizing, output-count helper and controller state encoding for the
// convolution multiplier pool.
package conv_pkg;
  localparam int W    = 16;
  localparam int F    = 3;
  localparam int K    = 3;
  localparam int E    = F * F * K;
  localparam int ACCW = 2 * W + $clog2(E);

  // Results per convolution: output side squared times filter count.
  function automatic int out_count(int n, int f, int s, int p, int nf);
    int o;
    o = (n + 2 * p - f) / s + 1;
    return o * o * nf;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: latches a window/filter pair, runs E signed MACs one per
// cycle, then holds the sum and requests the output port until granted.
module conv_mac_lane #(
  parameter int W    = 16,
  parameter int E    = 27,
  parameter int ACCW = 37
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [E*W-1:0]  i_img,
  input  logic [E*W-1:0]  i_flt,
  input  logic [15:0]     i_idx,
  input  logic            i_gnt,
  output logic            o_busy,
  output logic            o_req,
  output logic [ACCW-1:0] o_acc,
  output logic [15:0]     o_idx
);
  localparam int CW = $clog2(E);

  logic [E*W-1:0]         r_img, r_flt;
  logic [CW-1:0]          r_cnt;
  logic signed [ACCW-1:0] r_acc;
  logic [15:0]            r_idx;
  logic                   r_busy, r_req;

  logic signed [W-1:0]    w_a, w_b;
  logic signed [2*W-1:0]  w_prod;
  logic signed [ACCW-1:0] w_prod_x;

  assign w_a      = r_img[r_cnt*W +: W];
  assign w_b      = r_flt[r_cnt*W +: W];
  assign w_prod   = w_a * w_b;
  assign w_prod_x = {{(ACCW-2*W){w_prod[2*W-1]}}, w_prod};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_img <= '0; r_flt <= '0; r_cnt <= '0; r_acc <= '0;
      r_idx <= '0; r_busy <= 1'b0; r_req <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0; r_acc <= '0; r_idx <= '0;
      r_busy <= 1'b0; r_req <= 1'b0;
    end else if (i_load) begin
      r_img  <= i_img;
      r_flt  <= i_flt;
      r_idx  <= i_idx;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_busy <= 1'b1;
      r_req  <= 1'b0;
    end else if (i_gnt) begin
      r_busy <= 1'b0;
      r_req  <= 1'b0;
    end else if (r_busy && !r_req) begin
      r_acc <= r_acc + w_prod_x;
      r_cnt <= r_cnt + 1'b1;
      // Last element folded in on this edge; the sum is final from now on.
      if (r_cnt == CW'(E-1)) r_req <= 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_req  = r_req;
  assign o_acc  = r_acc;
  assign o_idx  = r_idx;
endmodule

// File: rtl/conv_mac_pool.sv
// NL-lane multiplier pool: job dispatch, round-robin result port, occupancy
// mask and partial/full completion indications for the conv controller.
module conv_mac_pool #(
  parameter int W     = conv_pkg::W,
  parameter int F     = conv_pkg::F,
  parameter int K     = conv_pkg::K,
  parameter int NL    = 4,
  parameter int TOTAL = conv_pkg::out_count(32, 3, 1, 0, 3),
  localparam int E    = F * F * K,
  localparam int ACCW = 2 * W + $clog2(E),
  localparam int LW   = $clog2(NL)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [LW-1:0]   job_lane,
  input  logic [E*W-1:0]  job_img,
  input  logic [E*W-1:0]  job_flt,
  output logic [NL-1:0]   mult_busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data,
  output logic [15:0]     res_idx,
  output logic            conv_done_partial,
  output logic            conv_done_full
);
  import conv_pkg::*;

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_jobs, r_res_cnt;
  logic [LW-1:0]         r_ptr, r_sel, w_pick, w_sel;
  logic                  r_lock;
  logic [NL-1:0]         r_busy_prev;

  logic [NL-1:0]         w_busy, w_req, w_load, w_gnt;
  logic [NL-1:0][ACCW-1:0] w_acc;
  logic [NL-1:0][15:0]   w_idx;
  logic                  w_accept, w_hs;

  conv_mac_lane #(.W(W), .E(E), .ACCW(ACCW)) u_lane [NL-1:0] (
    .i_clk (clk),     .i_rstn(rstn),    .i_clr (start),
    .i_load(w_load),  .i_img (job_img), .i_flt (job_flt),
    .i_idx (r_jobs),  .i_gnt (w_gnt),   .o_busy(w_busy),
    .o_req (w_req),   .o_acc (w_acc),   .o_idx (w_idx)
  );

  assign job_ready = (r_state == RUN) && !w_busy[job_lane] &&
                     (r_jobs < 16'(TOTAL)) && !start;
  assign w_accept  = job_valid && job_ready;

  // Lowest offset from the pointer wins; once presented, the choice is
  // locked so data/idx stay put while the consumer stalls.
  always_comb begin
    w_pick = r_ptr;
    for (int o = NL - 1; o >= 0; o--)
      if (w_req[r_ptr + LW'(o)]) w_pick = r_ptr + LW'(o);
  end

  assign w_sel     = r_lock ? r_sel : w_pick;
  assign res_valid = |w_req;
  assign w_hs      = res_valid && res_ready;
  assign res_data  = res_valid ? w_acc[w_sel] : '0;
  assign res_idx   = res_valid ? w_idx[w_sel] : '0;

  for (genvar l = 0; l < NL; l++) begin : g_sel
    assign w_load[l] = w_accept && (job_lane == LW'(l));
    assign w_gnt[l]  = w_hs && (w_sel == LW'(l));
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) w_state_nxt = RUN;
    else case (r_state)
      RUN:     if (w_hs && r_res_cnt == 16'(TOTAL - 1)) w_state_nxt = DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE; r_jobs <= '0; r_res_cnt <= '0;
      r_ptr <= '0; r_sel <= '0; r_lock <= 1'b0; r_busy_prev <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_jobs <= '0; r_res_cnt <= '0;
        r_ptr <= '0; r_sel <= '0; r_lock <= 1'b0; r_busy_prev <= '0;
      end else begin
        if (w_accept) r_jobs <= r_jobs + 1'b1;
        if (w_hs) begin
          r_res_cnt <= r_res_cnt + 1'b1;
          r_ptr     <= w_sel + 1'b1;
          r_lock    <= 1'b0;
        end else if (res_valid) begin
          r_lock <= 1'b1;
          r_sel  <= w_sel;
        end
        r_busy_prev <= w_busy;
      end
    end
  end

  assign mult_busy         = w_busy;
  assign conv_done_full    = (r_state == DONE);
  // Final batch lands in DONE, so it never raises a partial pulse.
  assign conv_done_partial = (r_state == RUN) && (|r_busy_prev) && !(|w_busy) &&
                             (r_res_cnt < 16'(TOTAL));
endmodule

// File: tb/tb_conv_mac_pool.sv
// Directed bench for conv_mac_pool: latency, signed math, arbitration,
// busy-lane rejection, a full 2700-job convolution and abort behaviour.
module tb_conv_mac_pool;
  localparam int W = 16, F = 3, K = 3, NL = 4, TOTAL = 2700;
  localparam int E = F * F * K, ACCW = 2 * W + $clog2(E), LW = $clog2(NL);

  logic            clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic            job_valid = 1'b0, job_ready;
  logic [LW-1:0]   job_lane = '0;
  logic [E*W-1:0]  job_img = '0, job_flt = '0;
  logic [NL-1:0]   mult_busy;
  logic            res_valid, res_ready = 1'b0;
  logic [ACCW-1:0] res_data;
  logic [15:0]     res_idx;
  logic            conv_done_partial, conv_done_full;

  int checks = 0, errors = 0;
  int sent, got, dup, bad, early_full;
  bit seen [TOTAL];

  conv_mac_pool #(.W(W), .F(F), .K(K), .NL(NL), .TOTAL(TOTAL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .job_valid(job_valid),
    .job_ready(job_ready), .job_lane(job_lane), .job_img(job_img),
    .job_flt(job_flt), .mult_busy(mult_busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .conv_done_partial(conv_done_partial), .conv_done_full(conv_done_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [E*W-1:0] fill(input logic [W-1:0] v);
    logic [E*W-1:0] r;
    r = '0;
    for (int e = 0; e < E; e++) r[e*W +: W] = v;
    return r;
  endfunction

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input int lane, input logic [W-1:0] iv, input logic [W-1:0] fv);
    job_lane = LW'(lane); job_img = fill(iv); job_flt = fill(fv); job_valid = 1'b1;
    #1 chk("job_ready_on_send", job_ready, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    chk(tag, res_valid, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_busy", mult_busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_partial", conv_done_partial, 0);
    chk("rst_full", conv_done_full, 0);
    rstn = 1'b1; tick();
    chk("idle_job_ready", job_ready, 0);

    // Basic job: 27 * 2 * 3 = 162, latency check
    do_start();
    send(0, 16'd2, 16'd3);
    chk("basic_busy_set", mult_busy, 4'b0001);
    repeat (26) tick();
    chk("basic_not_early", res_valid, 0);
    tick();
    chk("basic_valid", res_valid, 1);
    chk("basic_data", res_data, 162);
    chk("basic_idx", res_idx, 0);
    res_ready = 1'b1; tick();
    chk("basic_busy_clr", mult_busy, 0);
    chk("basic_partial", conv_done_partial, 1);
    tick();
    chk("basic_partial_once", conv_done_partial, 0);

    // Signed extremes: 27 * 2^30, and a negative sum 27 * -1 * 5
    send(1, 16'h8000, 16'h8000);
    wait_valid("signed_wait");
    chk("signed_max", res_data, 64'd28991029248);
    chk("signed_idx", res_idx, 1);
    tick();
    send(2, 16'hFFFF, 16'd5);
    wait_valid("neg_wait");
    chk("signed_neg", longint'($signed(res_data)), -135);
    chk("neg_idx", res_idx, 2);
    tick();

    // Contention: four lanes back to back, consumer stalled 40 cycles
    res_ready = 1'b0;
    do_start();
    for (int l = 0; l < NL; l++) send(l, W'(l + 1), 16'd1);
    repeat (40) tick();
    chk("cont_all_busy", mult_busy, 4'hF);
    chk("cont_valid", res_valid, 1);
    chk("cont_data0", res_data, 27);
    chk("cont_idx0", res_idx, 0);
    res_ready = 1'b1;
    for (int l = 1; l < NL; l++) begin
      tick();
      chk("cont_busy_drain", mult_busy, (4'hF << l) & 4'hF);
      chk("cont_data", res_data, 27 * (l + 1));
      chk("cont_idx", res_idx, l);
    end
    tick();
    chk("cont_busy_empty", mult_busy, 0);
    chk("cont_partial", conv_done_partial, 1);

    // Busy lane rejected, retarget accepted
    send(2, 16'd7, 16'd1);
    job_lane = 2'd2; job_img = fill(16'd100); job_flt = fill(16'd100); job_valid = 1'b1;
    #1 chk("busy_lane_ready", job_ready, 0);
    tick(); job_valid = 1'b0;
    chk("busy_lane_mask", mult_busy, 4'b0100);
    send(3, 16'd1, 16'd1);
    chk("retarget_mask", mult_busy, 4'b1100);
    wait_valid("busy_wait2");
    chk("busy_lane_data", res_data, 189);
    chk("busy_lane_idx", res_idx, 4);
    tick();
    wait_valid("busy_wait3");
    chk("retarget_data", res_data, 27);
    chk("retarget_idx", res_idx, 5);
    tick();

    // Full convolution with random consumer backpressure
    do_start();
    sent = 0; got = 0; dup = 0; bad = 0; early_full = 0;
    for (int cyc = 0; cyc < 60000 && got < TOTAL; cyc++) begin
      res_ready = 1'($urandom_range(0, 1));
      job_valid = 1'b0;
      if (sent < TOTAL) begin
        for (int l = NL - 1; l >= 0; l--)
          if (!mult_busy[l]) begin job_valid = 1'b1; job_lane = LW'(l); end
        job_img = fill(16'd1); job_flt = fill(16'd1);
      end
      #1;
      if (conv_done_full) early_full++;
      if (job_valid && job_ready) sent++;
      if (res_valid && res_ready) begin
        if (res_data != 27) bad++;
        if (res_idx >= TOTAL || seen[res_idx]) dup++;
        else seen[res_idx] = 1'b1;
        got++;
      end
      @(posedge clk); #1;
    end
    chk("full_results", got, TOTAL);
    chk("full_jobs", sent, TOTAL);
    chk("full_dup_idx", dup, 0);
    chk("full_bad_data", bad, 0);
    chk("full_early_done", early_full, 0);
    job_valid = 1'b1; job_lane = '0; res_ready = 1'b0;
    #1;
    chk("full_done", conv_done_full, 1);
    chk("full_no_partial", conv_done_partial, 0);
    chk("done_job_ready", job_ready, 0);
    tick(); job_valid = 1'b0;
    chk("full_done_hold", conv_done_full, 1);
    chk("full_no_partial2", conv_done_partial, 0);

    // Abort via start, then via asynchronous reset
    do_start();
    chk("restart_full_clr", conv_done_full, 0);
    send(0, 16'd1, 16'd1);
    send(1, 16'd1, 16'd1);
    repeat (5) tick();
    chk("abort_busy_pre", mult_busy, 4'b0011);
    do_start();
    chk("abort_busy", mult_busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_partial", conv_done_partial, 0);
    chk("abort_full", conv_done_full, 0);
    send(0, 16'd1, 16'd2);
    wait_valid("abort_wait");
    chk("abort_restart_data", res_data, 54);
    chk("abort_restart_idx", res_idx, 0);
    #3 rstn = 1'b0;
    #1;
    chk("rstn_valid", res_valid, 0);
    chk("rstn_busy", mult_busy, 0);
    chk("rstn_data", res_data, 0);
    chk("rstn_idx", res_idx, 0);
    chk("rstn_job_ready", job_ready, 0);
    tick(); rstn = 1'b1; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_mac_pool.md
# conv_mac_pool

Multiplier-pool responder for the convolution controller. It accepts window/filter jobs dispatched to specific lanes and computes one signed F×F×K dot product per job, one MAC per cycle per lane. It returns results through a round-robin output port. It also drives the lane-occupancy mask and the `conv_done_partial` / `conv_done_full` indications that the controller FSM consumes.

## Interface
Parameters:
- `W`, 16: operand width, signed two's complement.
- `F`, 3: filter side.
- `K`, 3: channels.
- `NL`, 4: number of MAC lanes.
- `TOTAL`, 2700: results per convolution, equal to `((N-F)/S+1)^2*NF` for N=32, S=1, NF=3.

Derived:
- `E = F*F*K`.
- `ACCW = 2*W + $clog2(E)`.
- `LW = $clog2(NL)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that clears all state and begins a convolution.
- `job_valid` in 1: a job is offered.
- `job_ready` out 1: the job is accepted this cycle.
- `job_lane` in LW: target lane.
- `job_img` in E*W: window, element e at bits [e*W +: W], with e = (k*F + j)*F + i.
- `job_flt` in E*W: filter, same packing as `job_img`.
- `mult_busy` out NL: per-lane occupancy, 0 free, 1 occupied.
- `res_valid` out 1: a result is presented.
- `res_ready` in 1: the consumer accepts the result.
- `res_data` out ACCW: signed dot product.
- `res_idx` out 16: acceptance-order index of the job that produced the result.
- `conv_done_partial` out 1: one-cycle pulse.
- `conv_done_full` out 1: level.

## Operation
Top FSM states:
- `IDLE`: reached on reset. `start` moves to `RUN`.
- `RUN`: accepts jobs. Moves to `DONE` when the accepted-result count reaches TOTAL.
- `DONE`: holds `conv_done_full`=1. `start` moves to `RUN`.

`start` in any state:
- Clears the lanes, `mult_busy`, the job index counter and the result counter.
- Enters `RUN`.
- Takes priority over a `job_valid` in the same cycle; that job is not accepted.

Job acceptance:
- `job_ready = (state==RUN) && !mult_busy[job_lane] && (jobs_accepted < TOTAL)`.
- On `job_valid && job_ready`, the lane:
  - latches the operands;
  - takes `res_idx = jobs_accepted`;
  - sets its `mult_busy` bit.
- `jobs_accepted` then increments.

Lane behaviour:
- Element counter runs 0..E-1.
- Accumulator: `acc <= acc + signed(img[e]) * signed(flt[e])`, full precision, no saturation, starting from 0.
- After E MACs the lane holds its result and requests the output port.

Output arbitration:
- Round-robin among requesting lanes. The pointer advances to the granted lane + 1 after each handshake.
- `res_data` and `res_idx` are registered and stable while `res_valid && !res_ready`.
- On `res_valid && res_ready`, the granted lane clears its `mult_busy` bit and the result count increments.

Done indications:
- `conv_done_partial` pulses for one cycle, in `RUN` only, when `mult_busy` goes from nonzero to zero and the result count is below TOTAL.
- When the final result is handshaked, `conv_done_full` rises next cycle. No partial pulse is issued for the final batch.

## Timing
- Reset value of every output is 0.
- After `start` is sampled, `job_ready` can assert in the following cycle.
- Job accepted at edge t:
  - `mult_busy` is 1 from t+1;
  - MACs occur on edges t+1..t+E;
  - the lane requests the port from cycle t+E+1;
  - `res_valid` is asserted from cycle t+E+1 at the earliest, which is latency E+1 = 28 with no contention.
- Lane reuse: the lane's busy bit clears the cycle after its result handshake, so the lane can take a new job on the edge after the bit clears. No same-cycle reuse.
- Occupied-lane offer: `job_valid` targeting an occupied lane sees `job_ready`=0. The lane is not disturbed and no counter changes.
- Stall isolation: other lanes keep computing while one waits on `res_ready`.
- Reset mid-operation: all lanes, counters and outputs go to 0 immediately and asynchronously. Results in flight are discarded.

## Structure
- Package `conv_pkg` holds:
  - `W`, `F`, `K`, `E`, `ACCW`;
  - `function out_count(N,F,S,P,NF)` returning TOTAL;
  - the state enum `{IDLE, RUN, DONE}`.
- Sub-module `conv_mac_lane` provides one lane:
  - operand registers;
  - element counter;
  - accumulator;
  - `busy` / `req` / `gnt` handshake.
- The top instantiates NL lanes and contains the round-robin arbiter, the FSM and the counters.

## Test plan
- **Basic job:** reset, `start`, one job to lane 0 with all img elements = 2 and all flt elements = 3 → `res_data`=162, `res_idx`=0, `res_valid` at cycle +28, `mult_busy`[0] is 1 then 0. `conv_done_partial` pulses once.
- **Signed arithmetic:** img element = -32768 and flt element = -32768 in every position → `res_data` = 27·2^30 = 28991029248, with no overflow in ACCW=37.
- **Contention:** four jobs accepted on four consecutive cycles to lanes 0..3, `res_ready` held 0 for 40 cycles then 1 → results drain in lane order 0,1,2,3 with `res_idx` 0..3. `mult_busy` clears one bit per cycle.
- **Busy lane:** `job_valid` to lane 2 while lane 2 is busy → `job_ready`=0 and lane 2's result is unchanged. Retarget to lane 3 → accepted.
- **Full convolution:** TOTAL=2700 jobs streamed across all lanes with random `res_ready` → exactly 2700 results with unique `res_idx`. `conv_done_full` rises once after the last handshake; no partial pulse for the final batch. `job_ready`=0 in `DONE`.
- **Abort:** `start` asserted mid-run with lanes busy, and `rstn` pulsed low while `res_valid`=1 → all outputs are 0 the next cycle (for `start`) or immediately (for `rstn`). After `start` the counters restart at `res_idx`=0.
